// File: rtl/mic_ram_frame_writer.sv
// rtl/mic_ram_frame_writer.sv - packs 16-bit mic samples into a ping-pong frame buffer in shared RAM
//
// Purpose:
//    Fabric-side write master for the second port of the Nios system's shared
//    on-chip RAM. Microphone samples are packed two per 32-bit word, low
//    sample in bits [15:0], and written into a buffer split into two halves
//    of 2^(ADDR_W-1) words. Each time a half fills, irq_new pulses so the CPU
//    can drain that half while the other one fills.
//
// Build option:
//    MIC_FRAME_HEADER_EN - when defined, word 0 of every half carries a
//    header {16'hA55A, frame_seq} and sample data fills offsets 1..N-1.
//
// Ports:
//    clk_clk          system clock shared with the Nios system
//    reset_reset_n    synchronous active-low reset
//    enable           capture enable
//    smp_valid        sample strobe
//    smp_data         16-bit two's complement sample
//    smp_ready        sample taken when smp_valid && smp_ready
//    ram_address      RAM word address       (ram_block_s2_address)
//    ram_chipselect   RAM chip select        (ram_block_s2_chipselect)
//    ram_clken        RAM clock enable       (ram_block_s2_clken)
//    ram_write        RAM write strobe       (ram_block_s2_write)
//    ram_writedata    RAM write data         (ram_block_s2_writedata)
//    ram_byteenable   RAM byte enables       (ram_block_s2_byteenable)
//    irq_new          half-complete pulse    (ext_irq_adapter_new_signal)
//    buf_half         index of the most recently completed half
//    frame_seq        count of completed halves, wraps at 16 bits

module mic_ram_frame_writer #(
   parameter int ADDR_W    = 10,
   parameter int IRQ_PULSE = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              enable,
   input  logic              smp_valid,
   input  logic [15:0]       smp_data,
   output logic              smp_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_clken,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   output logic [3:0]        ram_byteenable,
   output logic              irq_new,
   output logic              buf_half,
   output logic [15:0]       frame_seq
);

   localparam logic [7:0]        IRQ_LOAD = 8'(IRQ_PULSE);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
`ifdef MIC_FRAME_HEADER_EN
      , S_HDR = 2'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]       lo_q, lo_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              wr_q, wr_d;
   logic              irq_q, irq_d;
   logic [7:0]        irq_cnt_q, irq_cnt_d;
   logic              half_q, half_d;
   logic [15:0]       seq_q, seq_d;

   logic              accept;
   logic              do_write;
   logic [31:0]       new_wdata;
   logic [3:0]        new_be;
   logic              half_end;

   // Ready is gated by enable directly so a sample offered in the cycle
   // enable falls is never taken.
   assign smp_ready = enable && ((state_q == S_LO) || (state_q == S_HI));
   assign accept    = smp_valid && smp_ready;

   // The word being issued at wr_ptr is the last of its half.
   assign half_end  = &wr_ptr_q[ADDR_W-2:0];

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      lo_d      = lo_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      wr_d      = 1'b0;
      irq_d     = 1'b0;
      irq_cnt_d = irq_cnt_q;
      half_d    = half_q;
      seq_d     = seq_q;
      do_write  = 1'b0;
      new_wdata = 32'h0;
      new_be    = 4'h0;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               wr_ptr_d = '0;
`ifdef MIC_FRAME_HEADER_EN
               state_d  = S_HDR;
`else
               state_d  = S_LO;
`endif
            end
         end
`ifdef MIC_FRAME_HEADER_EN
         S_HDR: begin
            // frame_seq has not yet counted the half that starts here.
            do_write  = 1'b1;
            new_wdata = {16'hA55A, seq_q};
            new_be    = 4'hF;
            state_d   = S_LO;
         end
`endif
         S_LO: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (accept) begin
               lo_d    = smp_data;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (!enable) begin
               // Flush the lone low sample as a half-width write.
               do_write  = 1'b1;
               new_wdata = {16'h0, lo_q};
               new_be    = 4'h3;
               state_d   = S_IDLE;
            end else if (accept) begin
               do_write  = 1'b1;
               new_wdata = {smp_data, lo_q};
               new_be    = 4'hF;
               state_d   = S_LO;
`ifdef MIC_FRAME_HEADER_EN
               if (half_end) begin
                  state_d = S_HDR;
               end
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pulse countdown; irq_new drops in the cycle the count reaches zero.
      if (irq_cnt_q != 8'd0) begin
         irq_cnt_d = irq_cnt_q - 8'd1;
         irq_d     = (irq_cnt_q != 8'd1);
      end

      if (do_write) begin
         wr_d     = 1'b1;
         addr_d   = wr_ptr_q;
         wdata_d  = new_wdata;
         be_d     = new_be;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         // Completion reloads the counter, so back-to-back completions
         // stretch one pulse rather than producing two.
         if (half_end) begin
            half_d    = wr_ptr_q[ADDR_W-1];
            seq_d     = seq_q + 16'd1;
            irq_cnt_d = IRQ_LOAD;
            irq_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         lo_q      <= 16'h0;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         be_q      <= 4'h0;
         wr_q      <= 1'b0;
         irq_q     <= 1'b0;
         irq_cnt_q <= 8'd0;
         half_q    <= 1'b0;
         seq_q     <= 16'h0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         lo_q      <= lo_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         wr_q      <= wr_d;
         irq_q     <= irq_d;
         irq_cnt_q <= irq_cnt_d;
         half_q    <= half_d;
         seq_q     <= seq_d;
      end
   end

   assign ram_address    = addr_q;
   assign ram_chipselect = wr_q;
   assign ram_clken      = wr_q;
   assign ram_write      = wr_q;
   assign ram_writedata  = wdata_q;
   assign ram_byteenable = be_q;
   assign irq_new        = irq_q;
   assign buf_half       = half_q;
   assign frame_seq      = seq_q;

endmodule
